rs232_fifo_tx: RTL and testbench

- RS232 transmitter on the read side of the byte FIFO.
- While the FIFO is not empty and the block is enabled, it pops one word per frame using a single-clock pop_clock strobe and latches the word.
- It serialises the word onto the tx line as start bit, data bits LSB first, optional parity bit, then stop bit(s).
- Sits between the FIFO's pop port and the UART pad.

---
 rtl/rs232_fifo_tx_if.sv | 32 +++
 rtl/rs232_fifo_tx.sv | 211 +++++++++++++++++++++
 tb/tb_rs232_fifo_tx.sv | 335 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rs232_fifo_tx_if.sv
// ----------------------------------------------------------------------------
// rs232_fifo_tx_if
// Pop-side link between a byte FIFO and the RS232 transmitter.
//
// Signals:
//   fifo_empty      FIFO -> TX   high when the FIFO holds no data
//   fifo_data       FIFO -> TX   FIFO read word, valid the clk after a pop
//   fifo_pop_clock  TX -> FIFO   one-clk pop strobe
//
// Modports:
//   master  transmitter side (drives the pop strobe)
//   slave   FIFO side (drives empty flag and read data)
// ----------------------------------------------------------------------------
interface rs232_fifo_tx_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_data;
    logic                  fifo_pop_clock;

    modport master (
        input  fifo_empty,
        input  fifo_data,
        output fifo_pop_clock
    );

    modport slave (
        output fifo_empty,
        output fifo_data,
        input  fifo_pop_clock
    );
endinterface

// File: rtl/rs232_fifo_tx.sv
// ----------------------------------------------------------------------------
// rs232_fifo_tx
// RS232 transmitter fed from the read side of a byte FIFO. While enabled and
// the FIFO is not empty it pops one word, latches it, and sends it as
// start bit, DATA_WIDTH data bits LSB first, optional parity, stop bit(s).
//
// Parameters:
//   CLKS_PER_BIT  clk cycles per serial bit (>= 2)
//   DATA_WIDTH    data bits per frame (matches the FIFO word)
//   PARITY        0 = none, 1 = odd, 2 = even
//   STOP_BITS     1 or 2
//
// Ports:
//   i_clk         system clock, rising edge
//   i_rst         synchronous active-high reset
//   i_enable      allows new frames to start; never aborts a running frame
//   io_fifo       FIFO pop port (empty flag, read data, pop strobe)
//   o_tx          serial line, idle high
//   o_busy        high in every state except idle
//   o_frame_done  one-clk pulse on the last clk of the final stop bit
// ----------------------------------------------------------------------------
module rs232_fifo_tx #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned PARITY       = 0,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_enable,
    rs232_fifo_tx_if.master io_fifo,
    output logic            o_tx,
    output logic            o_busy,
    output logic            o_frame_done
);

    localparam int unsigned BaudW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned BitW  = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [BaudW-1:0] BaudLast = BaudW'(CLKS_PER_BIT - 1);
    localparam logic [BaudW-1:0] BaudOne  = BaudW'(1);
    localparam logic [BitW-1:0]  DataLast = BitW'(DATA_WIDTH - 1);
    localparam logic [BitW-1:0]  StopLast = BitW'(STOP_BITS - 1);
    localparam logic [BitW-1:0]  BitOne   = BitW'(1);

    typedef enum logic [2:0] {
        StIdle,
        StPop,
        StSettle,
        StStart,
        StData,
        StParity,
        StStop
    } state_e;

    // Frame state
    state_e                r_state;
    logic [BaudW-1:0]      r_baud;
    logic [BitW-1:0]       r_bit;
    logic [DATA_WIDTH-1:0] r_shift;
    logic                  r_parity;

    // Registered outputs
    logic                  r_tx;
    logic                  r_pop;
    logic                  r_busy;
    logic                  r_done;

    // Next-state values
    state_e                w_state_d;
    logic [BaudW-1:0]      w_baud_d;
    logic [BitW-1:0]       w_bit_d;
    logic [DATA_WIDTH-1:0] w_shift_d;
    logic                  w_parity_d;
    logic                  w_tx_d;
    logic                  w_pop_d;
    logic                  w_busy_d;
    logic                  w_done_d;
    logic                  w_baud_last;

    always_comb begin
        w_state_d   = r_state;
        w_baud_d    = r_baud;
        w_bit_d     = r_bit;
        w_shift_d   = r_shift;
        w_parity_d  = r_parity;
        w_baud_last = (r_baud == BaudLast);

        unique case (r_state)
            StIdle: begin
                // The empty flag is only looked at here, so no pop can be
                // issued against an empty FIFO.
                if (i_enable && !io_fifo.fifo_empty) begin
                    w_state_d = StPop;
                end
            end

            StPop: begin
                w_state_d = StSettle;
            end

            StSettle: begin
                // FIFO read data is valid one clk after the pop strobe.
                w_shift_d  = io_fifo.fifo_data;
                w_parity_d = (^io_fifo.fifo_data) ^ (PARITY == 32'd1);
                w_baud_d   = '0;
                w_bit_d    = '0;
                w_state_d  = StStart;
            end

            StStart: begin
                if (w_baud_last) begin
                    w_baud_d  = '0;
                    w_bit_d   = '0;
                    w_state_d = StData;
                end else begin
                    w_baud_d = r_baud + BaudOne;
                end
            end

            StData: begin
                if (w_baud_last) begin
                    w_baud_d  = '0;
                    w_shift_d = r_shift >> 1;
                    if (r_bit == DataLast) begin
                        w_bit_d   = '0;
                        w_state_d = (PARITY != 0) ? StParity : StStop;
                    end else begin
                        w_bit_d = r_bit + BitOne;
                    end
                end else begin
                    w_baud_d = r_baud + BaudOne;
                end
            end

            StParity: begin
                if (w_baud_last) begin
                    w_baud_d  = '0;
                    w_bit_d   = '0;
                    w_state_d = StStop;
                end else begin
                    w_baud_d = r_baud + BaudOne;
                end
            end

            StStop: begin
                // r_bit counts stop bits here.
                if (w_baud_last) begin
                    w_baud_d = '0;
                    if (r_bit == StopLast) begin
                        w_bit_d   = '0;
                        w_state_d = StIdle;
                    end else begin
                        w_bit_d = r_bit + BitOne;
                    end
                end else begin
                    w_baud_d = r_baud + BaudOne;
                end
            end

            default: begin
                w_state_d = StIdle;
                w_baud_d  = '0;
                w_bit_d   = '0;
            end
        endcase

        // Outputs are decoded from the next state so they leave flops and
        // line up with the state they describe.
        case (w_state_d)
            StStart:  w_tx_d = 1'b0;
            StData:   w_tx_d = w_shift_d[0];
            StParity: w_tx_d = w_parity_d;
            default:  w_tx_d = 1'b1;
        endcase

        w_pop_d  = (w_state_d == StPop);
        w_busy_d = (w_state_d != StIdle);
        w_done_d = (w_state_d == StStop) && (w_baud_d == BaudLast) && (w_bit_d == StopLast);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= StIdle;
            r_baud   <= '0;
            r_bit    <= '0;
            r_shift  <= '0;
            r_parity <= 1'b0;
            r_tx     <= 1'b1;
            r_pop    <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_d;
            r_baud   <= w_baud_d;
            r_bit    <= w_bit_d;
            r_shift  <= w_shift_d;
            r_parity <= w_parity_d;
            r_tx     <= w_tx_d;
            r_pop    <= w_pop_d;
            r_busy   <= w_busy_d;
            r_done   <= w_done_d;
        end
    end

    assign io_fifo.fifo_pop_clock = r_pop;
    assign o_tx                   = r_tx;
    assign o_busy                 = r_busy;
    assign o_frame_done           = r_done;

endmodule

// File: tb/tb_rs232_fifo_tx.sv
// ----------------------------------------------------------------------------
// tb_rs232_fifo_tx
// Four transmitters at CLKS_PER_BIT = 4 share a FIFO model; only the
// selected one sees a non-empty FIFO:
//   0: no parity, 1 stop   1: odd parity   2: even parity   3: 2 stop bits
// Bytes pushed into the FIFO model are also pushed to a scoreboard queue and
// popped when the corresponding serial frame has been captured.
// ----------------------------------------------------------------------------
module tb_rs232_fifo_tx;

    localparam int Cpb = 4;

    logic       clk;
    logic       rst;
    logic [3:0] en_v;
    logic [3:0] empty_v;
    logic [7:0] data_v;
    logic [3:0] pop_v;
    logic [3:0] tx_v;
    logic [3:0] busy_v;
    logic [3:0] done_v;

    for (genvar g = 0; g < 4; g++) begin : gen_dut
        rs232_fifo_tx_if #(.DATA_WIDTH(8)) u_if ();

        assign u_if.fifo_empty = empty_v[g];
        assign u_if.fifo_data  = data_v;
        assign pop_v[g]        = u_if.fifo_pop_clock;

        rs232_fifo_tx #(
            .CLKS_PER_BIT (Cpb),
            .DATA_WIDTH   (8),
            .PARITY       ((g == 1) ? 1 : ((g == 2) ? 2 : 0)),
            .STOP_BITS    ((g == 3) ? 2 : 1)
        ) u_dut (
            .i_clk        (clk),
            .i_rst        (rst),
            .i_enable     (en_v[g]),
            .io_fifo      (u_if.master),
            .o_tx         (tx_v[g]),
            .o_busy       (busy_v[g]),
            .o_frame_done (done_v[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // FIFO model and scoreboard
    logic [7:0] fifo_q [$];
    logic [7:0] exp_q  [$];
    int         sel = -1;
    int         pop_cnt  [4];
    int         done_cnt [4];
    int         bad_pop;

    int         n_checks;
    int         n_err;

    // Capture buffers for one frame
    logic        tr_tx   [64];
    logic        tr_busy [64];
    logic        tr_done [64];
    logic [15:0] last_obs;

    // FIFO model: pops on the strobe, presents the popped word, refreshes empty
    initial begin
        empty_v = 4'hF;
        data_v  = 8'h00;
        bad_pop = 0;
        for (int g = 0; g < 4; g++) begin
            pop_cnt[g]  = 0;
            done_cnt[g] = 0;
        end
        forever begin
            @(negedge clk);
            for (int g = 0; g < 4; g++) begin
                if (pop_v[g] === 1'b1) begin
                    pop_cnt[g]++;
                    if (empty_v[g] || fifo_q.size() == 0) bad_pop++;
                    else data_v = fifo_q.pop_front();
                end
                if (done_v[g] === 1'b1) done_cnt[g]++;
            end
            for (int g = 0; g < 4; g++) begin
                empty_v[g] = !((g == sel) && (fifo_q.size() != 0));
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish (observed=timeout required=finish)");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        fifo_q.push_back(b);
        exp_q.push_back(b);
    endtask

    function automatic logic [15:0] frame_vec(input logic [7:0] d, input int par);
        logic [15:0] v;
        v    = '1;
        v[0] = 1'b0;
        for (int i = 0; i < 8; i++) v[1 + i] = d[i];
        if (par == 1) v[9] = ~(^d);
        else if (par == 2) v[9] = ^d;
        return v;
    endfunction

    task automatic wait_start(input string tag, input int g, input int budget, output int n);
        n = 0;
        while (tx_v[g] !== 1'b0 && n < budget) begin
            tick();
            n++;
        end
        chk({tag, "_start_seen"}, {31'd0, tx_v[g]}, 32'd0);
    endtask

    // Called on the first clk of the start bit; returns on the clk after the frame.
    task automatic frame(input string tag, input int g, input int par, input int stops,
                         input int drop_at);
        logic [7:0]  d;
        logic [15:0] ev;
        int          nb, len, unstable, done_n, done_idx, busy_lo;
        nb  = 9 + ((par != 0) ? 1 : 0) + stops;
        len = nb * Cpb;
        for (int i = 0; i < len; i++) begin
            tr_tx[i]   = tx_v[g];
            tr_busy[i] = busy_v[g];
            tr_done[i] = done_v[g];
            if (i == drop_at) en_v[g] = 1'b0;
            tick();
        end
        last_obs = '1;
        unstable = 0;
        for (int b = 0; b < nb; b++) begin
            last_obs[b] = tr_tx[b * Cpb];
            for (int k = 1; k < Cpb; k++) begin
                if (tr_tx[b * Cpb + k] !== tr_tx[b * Cpb]) unstable++;
            end
        end
        done_n   = 0;
        done_idx = -1;
        busy_lo  = 0;
        for (int i = 0; i < len; i++) begin
            if (tr_done[i] === 1'b1) begin
                done_n++;
                done_idx = i;
            end
            if (tr_busy[i] !== 1'b1) busy_lo++;
        end
        chk({tag, "_sb_entry"}, (exp_q.size() != 0) ? 32'd1 : 32'd0, 32'd1);
        if (exp_q.size() != 0) d = exp_q.pop_front();
        else d = 8'hxx;
        ev = frame_vec(d, par);
        chk({tag, "_bits"}, {16'd0, last_obs}, {16'd0, ev});
        chk({tag, "_unstable"}, unstable, 0);
        chk({tag, "_done_n"}, done_n, 1);
        chk({tag, "_done_idx"}, done_idx, len - 1);
        chk({tag, "_busy_lo"}, busy_lo, 0);
    endtask

    initial begin
        int n;
        int bad;
        int lows;
        int highs;
        n_checks = 0;
        n_err    = 0;
        rst      = 1'b1;
        en_v     = 4'h0;

        // Reset state
        repeat (3) tick();
        chk("rst_tx", {31'd0, tx_v[0]}, 32'd1);
        chk("rst_busy", {31'd0, busy_v[0]}, 32'd0);
        chk("rst_pop", {31'd0, pop_v[0]}, 32'd0);
        chk("rst_done", {31'd0, done_v[0]}, 32'd0);
        rst = 1'b0;
        tick();

        // Basic frame, 0xA5, no parity
        sel     = 0;
        en_v[0] = 1'b1;
        push(8'hA5);
        tick();
        chk("basic_pop_n1", {31'd0, pop_v[0]}, 32'd1);
        chk("basic_busy_n1", {31'd0, busy_v[0]}, 32'd1);
        tick();
        chk("basic_pop_n2", {31'd0, pop_v[0]}, 32'd0);
        chk("basic_tx_n2", {31'd0, tx_v[0]}, 32'd1);
        tick();
        chk("basic_tx_n3", {31'd0, tx_v[0]}, 32'd0);
        frame("basic", 0, 0, 1, -1);
        chk("basic_seq", {22'd0, last_obs[9:0]}, 32'h34A);
        chk("basic_idle_after", {31'd0, busy_v[0]}, 32'd0);

        // Parity variants
        sel     = 2;
        en_v[2] = 1'b1;
        push(8'hA5);
        wait_start("par_even_a5", 2, 20, n);
        frame("par_even_a5", 2, 2, 1, -1);
        chk("par_even_a5_bit", {31'd0, last_obs[9]}, 32'd0);

        sel     = 1;
        en_v[1] = 1'b1;
        push(8'hA5);
        wait_start("par_odd_a5", 1, 20, n);
        frame("par_odd_a5", 1, 1, 1, -1);
        chk("par_odd_a5_bit", {31'd0, last_obs[9]}, 32'd1);

        sel = 2;
        push(8'h07);
        wait_start("par_even_07", 2, 20, n);
        frame("par_even_07", 2, 2, 1, -1);
        chk("par_even_07_bit", {31'd0, last_obs[9]}, 32'd1);

        // Back-to-back burst
        sel = 0;
        push(8'h11);
        push(8'h22);
        push(8'h33);
        wait_start("burst0", 0, 20, n);
        frame("burst0", 0, 0, 1, -1);
        wait_start("burst1", 0, 20, n);
        chk("burst1_gap", n, 3);
        frame("burst1", 0, 0, 1, -1);
        wait_start("burst2", 0, 20, n);
        chk("burst2_gap", n, 3);
        frame("burst2", 0, 0, 1, -1);
        repeat (60) tick();
        chk("burst_pops", pop_cnt[0], 4);
        chk("burst_dones", done_cnt[0], 4);

        // Empty FIFO: quiet line
        bad = 0;
        for (int i = 0; i < 200; i++) begin
            if (pop_v[0] !== 1'b0 || tx_v[0] !== 1'b1 || busy_v[0] !== 1'b0) bad++;
            tick();
        end
        chk("empty_quiet", bad, 0);

        // Disabled with data present: no pop
        en_v[0] = 1'b0;
        push(8'h3C);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (pop_v[0] !== 1'b0 || busy_v[0] !== 1'b0) bad++;
        end
        chk("disabled_no_pop", bad, 0);
        en_v[0] = 1'b1;
        tick();
        chk("enable_pop", {31'd0, pop_v[0]}, 32'd1);
        wait_start("gated", 0, 20, n);
        frame("gated", 0, 0, 1, -1);

        // Enable dropped during data bit 2: frame completes, then holds
        push(8'h5A);
        push(8'h96);
        wait_start("drop", 0, 20, n);
        frame("drop", 0, 0, 1, 12);
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            if (pop_v[0] !== 1'b0 || busy_v[0] !== 1'b0) bad++;
            tick();
        end
        chk("drop_hold_idle", bad, 0);
        en_v[0] = 1'b1;
        wait_start("drop_resume", 0, 20, n);
        frame("drop_resume", 0, 0, 1, -1);

        // Reset during the third data bit
        push(8'hC3);
        push(8'h5A);
        wait_start("rstmid", 0, 20, n);
        repeat (12) tick();
        rst = 1'b1;
        tick();
        chk("rstmid_tx", {31'd0, tx_v[0]}, 32'd1);
        chk("rstmid_busy", {31'd0, busy_v[0]}, 32'd0);
        chk("rstmid_pop", {31'd0, pop_v[0]}, 32'd0);
        rst = 1'b0;
        void'(exp_q.pop_front());
        tick();
        chk("rstmid_repop", {31'd0, pop_v[0]}, 32'd1);
        wait_start("rstmid_full", 0, 20, n);
        frame("rstmid_full", 0, 0, 1, -1);

        // Two stop bits, data 0x00
        sel     = 3;
        en_v[3] = 1'b1;
        push(8'h00);
        wait_start("stop2", 3, 20, n);
        frame("stop2", 3, 0, 2, -1);
        lows  = 0;
        highs = 0;
        for (int i = 0; i < 36; i++) if (tr_tx[i] === 1'b0) lows++;
        for (int i = 36; i < 44; i++) if (tr_tx[i] === 1'b1) highs++;
        chk("stop2_low_clks", lows, 36);
        chk("stop2_high_clks", highs, 8);

        // Pop / frame_done accounting
        repeat (10) tick();
        chk("total_pops0", pop_cnt[0], 9);
        chk("total_dones0", done_cnt[0], 8);
        chk("total_pops1", pop_cnt[1], 1);
        chk("total_pops2", pop_cnt[2], 2);
        chk("total_dones2", done_cnt[2], 2);
        chk("total_pops3", pop_cnt[3], 1);
        chk("total_dones3", done_cnt[3], 1);
        chk("pop_while_empty", bad_pop, 0);
        chk("sb_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
